serial_uart: RTL

- Downstream peer of the processor's memory-mapped serial byte port.
- Consumes serial_out, serial_wren_out and serial_rden_out, and produces serial_in, serial_valid_in and serial_ready_in.
- Converts bytes to and from an 8N1 UART line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Buffers received bytes in a small FIFO so the single-cycle core can poll at its own pace.

---
 rtl/serial_uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/serial_uart.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_pkg.sv
// -----------------------------------------------------------------------------
// serial_uart_pkg
// Shared definitions for the serial_uart block: the 2-bit state encoding
// used by both the TX and RX framing FSMs, and the UART data width.
// -----------------------------------------------------------------------------
package serial_uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small show-ahead FIFO buffering received UART bytes.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   push          : write push_data (dropped when full unless popping too)
//   push_data     : byte to store
//   pop           : discard head entry (ignored when empty)
//   head          : oldest entry, valid whenever empty=0
//   empty, full   : occupancy status
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import serial_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q;
    logic [AW-1:0]             rd_ptr_q;
    logic [AW:0]               count_q;
    logic                      do_push;
    logic                      do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still succeeds when it coincides with a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/serial_uart.sv
// -----------------------------------------------------------------------------
// serial_uart
// Bridges the processor's memory-mapped serial byte port to an 8N1 UART line.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   serial_out       : byte to transmit, taken on serial_wren_out
//   serial_wren_out  : write strobe (ignored while serial_ready_in=0)
//   serial_rden_out  : pop strobe for the receive FIFO head
//   serial_in        : receive FIFO head (show-ahead), 0 when empty
//   serial_valid_in  : receive FIFO non-empty
//   serial_ready_in  : transmitter idle
//   uart_rx, uart_tx : serial line in / out, both idle high
//   rx_overrun       : sticky, byte dropped on full FIFO
//   rx_frame_err     : sticky, stop bit sampled low
// -----------------------------------------------------------------------------
module serial_uart
    import serial_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] serial_out,
    input  logic                      serial_wren_out,
    input  logic                      serial_rden_out,
    output logic [UART_DATA_BITS-1:0] serial_in,
    output logic                      serial_valid_in,
    output logic                      serial_ready_in,
    input  logic                      uart_rx,
    output logic                      uart_tx,
    output logic                      rx_overrun,
    output logic                      rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(UART_DATA_BITS - 1);

    // ---------------- transmitter ----------------
    uart_state_e               tx_state_q;
    logic [CW-1:0]             tx_cnt_q;
    logic [BW-1:0]             tx_bit_q;
    logic [UART_DATA_BITS-1:0] tx_shift_q;
    logic                      tx_q;
    logic                      tx_ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                UART_IDLE: begin
                    if (serial_wren_out) begin
                        tx_shift_q <= serial_out;
                        tx_q       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= UART_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == IDX_LAST) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= UART_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= UART_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= UART_IDLE;
            endcase
        end
    end

    assign uart_tx         = tx_q;
    assign serial_ready_in = tx_ready_q;

    // ---------------- receiver ----------------
    logic                      rx_meta_q;
    logic                      rx_sync_q;
    uart_state_e               rx_state_q;
    logic [CW-1:0]             rx_cnt_q;
    logic [BW-1:0]             rx_bit_q;
    logic [UART_DATA_BITS-1:0] rx_shift_q;
    logic                      rx_push_q;
    logic                      rx_frame_err_q;
    logic                      rx_overrun_q;

    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;

    // Synchroniser resets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // The half-bit START wait centres every later sample in its bit cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q     <= UART_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_push_q      <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            case (rx_state_q)
                UART_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? UART_IDLE : UART_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
                        if (rx_bit_q == IDX_LAST) begin
                            rx_state_q <= UART_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_push_q  <= rx_sync_q;
                        if (!rx_sync_q) begin
                            rx_frame_err_q <= 1'b1;
                        end
                        rx_state_q <= UART_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= UART_IDLE;
            endcase
        end
    end

    // A full FIFO only drops the byte when no pop frees a slot that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_overrun_q <= 1'b0;
        end else if (rx_push_q && fifo_full && !serial_rden_out) begin
            rx_overrun_q <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push_q),
        .push_data (rx_shift_q),
        .pop       (serial_rden_out),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FIFO storage is not reset, so the head is masked while empty.
    assign serial_in       = fifo_empty ? '0 : fifo_head;
    assign serial_valid_in = !fifo_empty;
    assign rx_overrun      = rx_overrun_q;
    assign rx_frame_err    = rx_frame_err_q;

endmodule
